// File: rtl/saradc_pkg.sv
// Shared encodings for the SAR CDAC controller: per-bit switch mode and FSM state.
package saradc_pkg;

    typedef enum logic [1:0] {
        SW_OFF = 2'd0,
        SW_IN  = 2'd1,
        SW_H   = 2'd2,
        SW_L   = 2'd3
    } sw_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_PREP   = 3'd2,
        ST_TRIAL  = 3'd3,
        ST_STROBE = 3'd4,
        ST_DECIDE = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/saradc_cdac_bit_drv.sv
// One CDAC bit group: registers a switch mode into one-hot CRI/CRH/CRL and their complements.
module saradc_cdac_bit_drv
    import saradc_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  sw_mode_e mode_i,
    output logic     cri_o,
    output logic     crh_o,
    output logic     crl_o,
    output logic     crib_o,
    output logic     crhb_o,
    output logic     crlb_o
);

    logic cri_q, cri_d;
    logic crh_q, crh_d;
    logic crl_q, crl_d;

    always_comb begin
        cri_d = (mode_i == SW_IN);
        crh_d = (mode_i == SW_H);
        crl_d = (mode_i == SW_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cri_q <= 1'b0;
            crh_q <= 1'b0;
            crl_q <= 1'b0;
        end else begin
            cri_q <= cri_d;
            crh_q <= crh_d;
            crl_q <= crl_d;
        end
    end

    // Complements come from the same flops so true/complement can never disagree.
    assign cri_o  = cri_q;
    assign crh_o  = crh_q;
    assign crl_o  = crl_q;
    assign crib_o = ~cri_q;
    assign crhb_o = ~crh_q;
    assign crlb_o = ~crl_q;

endmodule

// File: rtl/saradc_cdac_ctrl.sv
// SAR conversion controller: sample, then one PREP/TRIAL/STROBE/DECIDE step per bit, MSB first.
module saradc_cdac_ctrl
    import saradc_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NSAMPLE = 4
)
(
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             CMP,
    output logic             CMP_EN,
    output logic [NBITS-1:0] CRI,
    output logic [NBITS-1:0] CRH,
    output logic [NBITS-1:0] CRL,
    output logic [NBITS-1:0] CRIB,
    output logic [NBITS-1:0] CRHB,
    output logic [NBITS-1:0] CRLB,
    output logic             BUSY,
    output logic             VALID,
    output logic [NBITS-1:0] DATA
);

    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int CW = (NSAMPLE > 1) ? $clog2(NSAMPLE) : 1;
    localparam logic [BW-1:0] BIT_MSB  = BW'(NBITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSAMPLE - 1);

    state_e           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] result_q, result_d;
    logic [NBITS-1:0] data_q, data_d;
    logic             cmp_en_q, cmp_en_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    sw_mode_e         mode_d [NBITS];

    always_comb begin : fsm_next
        state_d  = state_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_SAMPLE;
                    cnt_d    = '0;
                    result_d = '0;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_PREP;
                    bit_d   = BIT_MSB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PREP:   state_d = ST_TRIAL;
            ST_TRIAL:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_DECIDE;
            ST_DECIDE: begin
                result_d[bit_q] = CMP;
                if (bit_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PREP;
                    bit_d   = bit_q - BW'(1);
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Switch modes are derived from the next state so the registered controls line up with the state.
    always_comb begin : mode_next
        for (int i = 0; i < NBITS; i++) begin
            mode_d[i] = SW_OFF;
            case (state_d)
                ST_SAMPLE: mode_d[i] = SW_IN;
                ST_PREP, ST_TRIAL, ST_STROBE, ST_DECIDE: begin
                    if (i > int'(bit_d)) begin
                        mode_d[i] = result_d[i] ? SW_H : SW_L;
                        // A just-cleared bit breaks from H before settling on L.
                        if (state_d == ST_PREP && i == int'(bit_d) + 1 && !result_d[i]) begin
                            mode_d[i] = SW_OFF;
                        end
                    end else if (i == int'(bit_d)) begin
                        mode_d[i] = (state_d == ST_PREP) ? SW_OFF : SW_H;
                    end else begin
                        mode_d[i] = (state_d == ST_PREP && bit_d == BIT_MSB) ? SW_OFF : SW_L;
                    end
                end
                default: mode_d[i] = SW_OFF;
            endcase
        end
    end

    always_comb begin : out_next
        cmp_en_d = (state_d == ST_STROBE);
        busy_d   = (state_d != ST_IDLE);
        valid_d  = (state_d == ST_DONE);
        data_d   = valid_d ? result_d : data_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            data_q   <= '0;
            cmp_en_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            data_q   <= data_d;
            cmp_en_q <= cmp_en_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    for (genvar g = 0; g < NBITS; g++) begin : g_bit
        saradc_cdac_bit_drv u_drv (
            .clk    (CLK),
            .rst_n  (RSTN),
            .mode_i (mode_d[g]),
            .cri_o  (CRI[g]),
            .crh_o  (CRH[g]),
            .crl_o  (CRL[g]),
            .crib_o (CRIB[g]),
            .crhb_o (CRHB[g]),
            .crlb_o (CRLB[g])
        );
    end

    assign CMP_EN = cmp_en_q;
    assign BUSY   = busy_q;
    assign VALID  = valid_q;
    assign DATA   = data_q;

endmodule

// File: tb/tb_saradc_cdac_ctrl.sv
// Bench for saradc_cdac_ctrl: cycle-indexed reference of the conversion schedule plus an ideal comparator.
module tb_saradc_cdac_ctrl;

    localparam int NBITS   = 8;
    localparam int NSAMPLE = 4;
    localparam int CONV    = NSAMPLE + 4 * NBITS;

    logic             CLK = 1'b0;
    logic             RSTN = 1'b0;
    logic             START = 1'b0;
    logic             CMP = 1'b0;
    logic             CMP_EN;
    logic [NBITS-1:0] CRI, CRH, CRL, CRIB, CRHB, CRLB;
    logic             BUSY, VALID;
    logic [NBITS-1:0] DATA;

    saradc_cdac_ctrl #(.NBITS(NBITS), .NSAMPLE(NSAMPLE)) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .START  (START),
        .CMP    (CMP),
        .CMP_EN (CMP_EN),
        .CRI    (CRI),
        .CRH    (CRH),
        .CRL    (CRL),
        .CRIB   (CRIB),
        .CRHB   (CRHB),
        .CRLB   (CRLB),
        .BUSY   (BUSY),
        .VALID  (VALID),
        .DATA   (DATA)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int             n_cmp = 0;
    int             n_err = 0;
    logic [NBITS-1:0] exp_q[$];
    logic [NBITS-1:0] exp_data = '0;
    logic [2:0]     prev_sw [NBITS];
    int             sw_viol = 0;
    int             cmp_en_cnt = 0;
    logic           prev_cmp_en = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected outputs c edges after the START-accepting edge (c < 0 or past DONE = idle).
    function automatic logic [63:0] model_word(input int c, input logic [NBITS-1:0] t,
                                               input logic [NBITS-1:0] d);
        logic [NBITS-1:0] ri, rh, rl;
        logic ce, bs, vl;
        ri = '0; rh = '0; rl = '0; ce = 1'b0; bs = 1'b0; vl = 1'b0;
        if (c >= 0 && c < NSAMPLE) begin
            ri = '1;
            bs = 1'b1;
        end else if (c >= NSAMPLE && c < CONV) begin
            int j, k, sub;
            j   = c - NSAMPLE;
            k   = NBITS - 1 - j / 4;
            sub = j % 4;
            bs  = 1'b1;
            ce  = (sub == 2);
            for (int i = 0; i < NBITS; i++) begin
                if (i > k) begin
                    if (t[i]) rh[i] = 1'b1;
                    else if (!(sub == 0 && i == k + 1)) rl[i] = 1'b1;
                end else if (i == k) begin
                    if (sub != 0) rh[i] = 1'b1;
                end else if (!(sub == 0 && k == NBITS - 1)) begin
                    rl[i] = 1'b1;
                end
            end
        end else if (c == CONV) begin
            bs = 1'b1;
            vl = 1'b1;
        end
        return {5'b0, d, ce, bs, vl, ri, rh, rl, ~ri, ~rh, ~rl};
    endfunction

    function automatic logic [63:0] dut_word();
        return {5'b0, DATA, CMP_EN, BUSY, VALID, CRI, CRH, CRL, CRIB, CRHB, CRLB};
    endfunction

    task automatic sw_monitor();
        for (int i = 0; i < NBITS; i++) begin
            logic [2:0] cur;
            cur = {CRI[i], CRH[i], CRL[i]};
            if ($countones(cur) > 1) sw_viol++;
            if (prev_sw[i] != 3'b000 && cur != 3'b000 && cur != prev_sw[i]) sw_viol++;
            prev_sw[i] = cur;
        end
        if (CMP_EN) cmp_en_cnt++;
    endtask

    // Comparator: 0/1 constant, or ideal compare of the trial code (bits on VREFH) against vin.
    task automatic drive_cmp(input int cmode, input logic [NBITS-1:0] vin);
        if (CMP_EN) begin
            if (cmode == 1)      CMP = 1'b0;
            else if (cmode == 2) CMP = 1'b1;
            else                 CMP = (CRH <= vin);
        end else if (!prev_cmp_en) begin
            CMP = 1'($urandom_range(0, 1));
        end
        prev_cmp_en = CMP_EN;
    endtask

    task automatic tick(input int cmode, input logic [NBITS-1:0] vin);
        @(negedge CLK);
        sw_monitor();
        drive_cmp(cmode, vin);
    endtask

    task automatic run_conv(input logic [NBITS-1:0] t, input int cmode, input logic [NBITS-1:0] vin,
                            input int abort_at, input bit pulses, input bit hold);
        int cnt0, viol0;
        cnt0  = cmp_en_cnt;
        viol0 = sw_viol;
        exp_q.push_back(t);
        START = 1'b1;
        @(posedge CLK);
        for (int c = 0; c <= CONV + 1; c++) begin
            tick(cmode, vin);
            if (c == CONV) exp_data = exp_q.pop_front();
            check_val($sformatf("conv%02h_cyc%0d", t, c), dut_word(), model_word(c, t, exp_data));
            START = (pulses && (c == 5 || c == 35)) || (hold && c >= CONV);
            if (c == abort_at) begin
                RSTN = 1'b0;
                void'(exp_q.pop_front());
                exp_data = '0;
                tick(cmode, vin);
                check_val("abort_reset", dut_word(), model_word(-1, '0, '0));
                RSTN = 1'b1;
                return;
            end
        end
        check_val($sformatf("conv%02h_cmp_en_pulses", t), 64'(cmp_en_cnt - cnt0), 64'(NBITS));
        check_val($sformatf("conv%02h_switch_rules", t), 64'(sw_viol - viol0), 64'd0);
    endtask

    initial begin
        logic [NBITS-1:0] v;
        int cnt0;
        for (int i = 0; i < NBITS; i++) prev_sw[i] = 3'b000;

        repeat (3) @(negedge CLK);
        check_val("reset_held", dut_word(), model_word(-1, '0, '0));
        RSTN = 1'b1;
        cnt0 = cmp_en_cnt;
        for (int i = 0; i < 5; i++) begin
            tick(0, '0);
            check_val($sformatf("idle_cyc%0d", i), dut_word(), model_word(-1, '0, '0));
        end
        check_val("idle_no_cmp_en", 64'(cmp_en_cnt - cnt0), 64'd0);

        run_conv(8'hA5, 0, 8'hA5, -1, 1'b0, 1'b0);
        run_conv(8'h00, 1, 8'($urandom), -1, 1'b0, 1'b0);
        run_conv(8'hFF, 2, 8'($urandom), -1, 1'b0, 1'b0);
        run_conv(8'h5A, 0, 8'h5A, -1, 1'b0, 1'b0);

        v = 8'($urandom);
        run_conv(v, 0, v, 20, 1'b0, 1'b0);
        v = 8'($urandom);
        run_conv(v, 0, v, -1, 1'b0, 1'b0);

        v = 8'($urandom);
        run_conv(v, 0, v, -1, 1'b1, 1'b1);
        v = 8'($urandom);
        run_conv(v, 0, v, -1, 1'b0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            v = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick(0, v);
            run_conv(v, 0, v, -1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
